// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the 2-read/1-write register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 4;
  localparam int ZERO_REG_IDX = 0;

  // Depth of the array for a given address width.
  function automatic int num_regs(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_wr_decoder.sv
// Write-select decoder: one-hot select of the register to load this cycle.
// Address 0 selects nothing when the hardwired zero register is enabled.
module regfile_wr_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                          ld,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          zero_reg_en,
  output logic [num_regs(ADDR_W)-1:0]   sel
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);

  // Decode the load request into a one-hot register select.
  always_comb begin
    sel = '0;
    if (ld && !(zero_reg_en && (addr == ZERO_ADDR))) begin
      sel[addr] = 1'b1;
    end else begin
      sel = '0;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file with one write port and two combinational read
// ports. Register 0 optionally reads as zero and ignores writes (ZERO_REG).
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to a read port addressing the register being written.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [ADDR_W-1:0]           rd_addr_a,
  input  logic [ADDR_W-1:0]           rd_addr_b,
  output logic [DATA_W-1:0]           rd_data_a,
  output logic [DATA_W-1:0]           rd_data_b,
  output logic [num_regs(ADDR_W)-1:0] wr_sel_q
);

  localparam int                NUM_REGS  = num_regs(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);

  logic                zero_en;
  logic [NUM_REGS-1:0] sel;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                fwd_a;
  logic                fwd_b;

  assign zero_en = (ZERO_REG != 0);

  regfile_wr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wr_decoder (
    .ld          (ld),
    .addr        (wr_addr),
    .zero_reg_en (zero_en),
    .sel         (sel)
  );

`ifdef REGFILE_BYPASS_EN
  // Forward only a write that will actually land; reset drops the write.
  assign fwd_a = !rst && sel[rd_addr_a];
  assign fwd_b = !rst && sel[rd_addr_b];
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // Storage array and write-select history; reset wins over a pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wr_sel_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sel[i]) begin
          regs[i] <= wr_data;
        end
      end
      wr_sel_q <= sel;
    end
  end

  // Read port A: zero register, then forwarding, then array contents.
  always_comb begin
    if (zero_en && (rd_addr_a == ZERO_ADDR)) begin
      rd_data_a = '0;
    end else if (fwd_a) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = regs[rd_addr_a];
    end
  end

  // Read port B: same priority as port A, independent address.
  always_comb begin
    if (zero_en && (rd_addr_b == ZERO_ADDR)) begin
      rd_data_b = '0;
    end else if (fwd_b) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = regs[rd_addr_b];
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: a directed vector table on the
// ZERO_REG=1 instance plus random traffic on both ZERO_REG=1 and ZERO_REG=0
// instances, all checked against an array-based reference model.
module tb_regfile_2r1w;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ld;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rda_z, rdb_z, rda_n, rdb_n;
  logic [15:0] sel_z, sel_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_z [16];
  logic [31:0] m_n [16];

  typedef struct {
    logic        rst;
    logic        ld;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [15:0] es;
  } vec_t;

  vec_t tbl[$];

  regfile_2r1w #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .ld(ld), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda_z), .rd_data_b(rdb_z), .wr_sel_q(sel_z)
  );

  regfile_2r1w #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst(rst), .ld(ld), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda_n), .rd_data_b(rdb_n), .wr_sel_q(sel_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected read value from the specification's rules.
  function automatic logic [31:0] model_rd(input bit zr, input logic [31:0] stored,
                                           input logic [3:0] a);
    if (zr && a == 4'd0) return 32'h0;
    if (BYP && ld && !rst && a == wr_addr) return wr_data;
    return stored;
  endfunction

  // Expected one-hot recorded at the coming edge.
  function automatic logic [15:0] model_sel(input bit zr);
    if (rst || !ld) return 16'h0;
    if (zr && wr_addr == 4'd0) return 16'h0;
    return 16'h1 << wr_addr;
  endfunction

  // One clock cycle: drive, check reads before the edge, clock, check wr_sel_q.
  task automatic step(input vec_t v, input bit use_tbl);
    logic [15:0] es_z, es_n;
    rst = v.rst; ld = v.ld; wr_addr = v.wa; wr_data = v.wd;
    rd_addr_a = v.ra; rd_addr_b = v.rb;
    #2;
    chk("rd_a_z", rda_z, model_rd(1'b1, m_z[v.ra], v.ra));
    chk("rd_b_z", rdb_z, model_rd(1'b1, m_z[v.rb], v.rb));
    chk("rd_a_n", rda_n, model_rd(1'b0, m_n[v.ra], v.ra));
    chk("rd_b_n", rdb_n, model_rd(1'b0, m_n[v.rb], v.rb));
    if (use_tbl) begin
      chk("tbl_rd_a", rda_z, v.ea);
      chk("tbl_rd_b", rdb_z, v.eb);
    end
    es_z = model_sel(1'b1);
    es_n = model_sel(1'b0);
    @(posedge clk);
    if (v.rst) begin
      for (int i = 0; i < 16; i++) begin
        m_z[i] = 32'h0;
        m_n[i] = 32'h0;
      end
    end else if (v.ld) begin
      if (v.wa != 4'd0) m_z[v.wa] = v.wd;
      m_n[v.wa] = v.wd;
    end
    #1;
    chk("wr_sel_z", {16'h0, sel_z}, {16'h0, es_z});
    chk("wr_sel_n", {16'h0, sel_n}, {16'h0, es_n});
    if (use_tbl) chk("tbl_wr_sel", {16'h0, sel_z}, {16'h0, v.es});
  endtask

  function automatic vec_t mk(input logic r, input logic l, input logic [3:0] wa,
                              input logic [31:0] wd, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [31:0] ea,
                              input logic [31:0] eb, input logic [15:0] es);
    vec_t v;
    v.rst = r; v.ld = l; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
    v.ea = ea; v.eb = eb; v.es = es;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [31:0] old_v;
    logic [3:0]  ia, ib;

    // Directed table for the ZERO_REG=1 instance.
    for (int i = 0; i < 16; i++) begin
      ia = 4'(i); ib = 4'(15 - i);
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0, ia, ib, 32'h0, 32'h0, 16'h0000));
    end
    tbl.push_back(mk(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 4'd5, 4'd5,
                     BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 16'h0020));
    tbl.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0, 4'd5, 4'd0, 32'hDEADBEEF, 32'h0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b1, 4'd0, 32'h12345678, 4'd0, 4'd0, 32'h0, 32'h0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd5, 32'h0, 32'hDEADBEEF, 16'h0000));
    for (int i = 1; i < 16; i++) begin
      ia = 4'(i);
      old_v = (i == 5) ? 32'hDEADBEEF : 32'h0;
      tbl.push_back(mk(1'b0, 1'b1, ia, 32'(i + 1), ia, 4'd0,
                       BYP ? 32'(i + 1) : old_v, 32'h0, 16'h1 << ia));
    end
    for (int i = 0; i < 16; i++) begin
      ia = 4'(i); ib = 4'(15 - i);
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0, ia, ib,
                       (i == 0) ? 32'h0 : 32'(i + 1),
                       (i == 15) ? 32'h0 : 32'(16 - i), 16'h0000));
    end
    tbl.push_back(mk(1'b0, 1'b1, 4'd3, 32'h1, 4'd3, 4'd3,
                     BYP ? 32'h1 : 32'h4, BYP ? 32'h1 : 32'h4, 16'h0008));
    tbl.push_back(mk(1'b0, 1'b1, 4'd3, 32'hA5A5A5A5, 4'd3, 4'd3,
                     BYP ? 32'hA5A5A5A5 : 32'h1, BYP ? 32'hA5A5A5A5 : 32'h1, 16'h0008));
    tbl.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0, 4'd3, 4'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b1, 4'd7, 32'h77, 4'd7, 4'd3,
                     BYP ? 32'h77 : 32'h8, 32'hA5A5A5A5, 16'h0080));
    tbl.push_back(mk(1'b1, 1'b1, 4'd7, 32'hCAFEF00D, 4'd7, 4'd7, 32'h77, 32'h77, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0, 4'd7, 4'd3, 32'h0, 32'h0, 16'h0000));

    // Bring the array to a known state.
    rst = 1'b1; ld = 1'b0; wr_addr = 4'd0; wr_data = 32'h0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    for (int i = 0; i < 16; i++) begin
      m_z[i] = 32'h0;
      m_n[i] = 32'h0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;

    foreach (tbl[k]) step(tbl[k], 1'b1);

    // Hand sequence: ZERO_REG=0 keeps a write to register 0.
    step(mk(1'b0, 1'b1, 4'd0, 32'h12345678, 4'd1, 4'd2, 32'h0, 32'h0, 16'h0), 1'b0);
    chk("zr0_sel", {16'h0, sel_n}, 32'h0000_0001);
    chk("zr1_sel", {16'h0, sel_z}, 32'h0);
    step(mk(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 32'h0, 32'h0, 16'h0), 1'b0);
    chk("zr0_rd0", rda_n, 32'h12345678);
    chk("zr1_rd0", rda_z, 32'h0);
    chk("zr0_sel_clr", {16'h0, sel_n}, 32'h0);

    // Randomised traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      v = mk(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), $urandom(), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 32'h0, 32'h0, 16'h0);
      if ($urandom_range(0, 3) == 0) v.ra = v.wa;
      if ($urandom_range(0, 3) == 0) v.rb = v.wa;
      step(v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised register file: one write port, two read ports.
- Successor to the team's 4-to-16 load-gated decoder. The decoder is now an internal write-select stage driving a real storage array.
- Register 0 is optionally hardwired to zero, preserving the existing "address 0 selects nothing" rule.
- Sits between the datapath's writeback stage and operand fetch.

Parameters:
- DATA_W, 32, register width in bits (>=1).
- ADDR_W, 4, address width; depth NUM_REGS = 2**ADDR_W (derived localparam, not overridable).
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary storage.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld  in  1  write enable (load).
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_a  out  DATA_W  read port A data.
- rd_data_b  out  DATA_W  read port B data.
- wr_sel_q  out  NUM_REGS  registered one-hot of the last accepted write; all-zero if none.

Behaviour:
- Reset:
  - rst=1 at a rising edge clears all NUM_REGS registers to 0 and wr_sel_q to 0.
  - rst overrides ld in the same cycle; no write occurs.
- Write-select decode (combinational):
  - sel = ld ? (1 << wr_addr) : 0.
  - If ZERO_REG=1 and wr_addr==0, sel = 0.
- Write:
  - At the rising edge with rst=0, every register i with sel[i]=1 loads wr_data.
  - At most one register is written per cycle; write latency is 1 cycle.
- wr_sel_q:
  - Loads sel at every non-reset edge.
  - Holds the one-hot for exactly one cycle after the write, then returns to 0 if ld=0.
  - A write to register 0 with ZERO_REG=1 gives wr_sel_q = 0.
- Reads:
  - Combinational from the array: rd_data_x = reg[rd_addr_x], zero latency.
  - If ZERO_REG=1 and rd_addr_x==0, rd_data_x = 0 regardless of stored contents.
- Same-cycle read and write to the same address: read returns the OLD value unless bypass is compiled in (see below).
- Both read ports may address the same register in the same cycle; both return the same value.
- Address range: wr_addr and rd_addr span exactly 0..NUM_REGS-1; there is no out-of-range case.
- Width rules: wr_data is stored unmodified; no sign extension or truncation.
- Reset mid-operation: a write presented in the reset cycle is dropped and must be re-issued.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if ld=1 and rd_addr_x==wr_addr (and not the hardwired zero register), rd_data_x = wr_data combinationally in the same cycle (write-through forwarding). Applies to both ports independently.
- Not defined: reads return array contents only; the new value is visible the cycle after the edge.
- Bypass is inhibited while rst=1.

Decomposition:
- Package regfile_pkg:
  - default DATA_W and ADDR_W constants;
  - a function computing NUM_REGS from ADDR_W;
  - the zero-register index constant (0).
- Sub-module regfile_wr_decoder (ADDR_W parameter):
  - inputs ld, addr, zero_reg_en; output one-hot sel;
  - purely combinational generalisation of the existing decoder.
- Storage, read muxes, bypass and wr_sel_q live in regfile_2r1w.

Test Plan:
- Reset, then read all 16 addresses on both ports -> all 0; wr_sel_q = 16'h0000.
- Write 32'hDEADBEEF to reg 5 (ld=1 one cycle), read A=5 next cycle -> 32'hDEADBEEF; wr_sel_q = 16'h0020 for one cycle, then 16'h0000.
- ZERO_REG=1: write 32'h12345678 to reg 0, read A=0 -> 0, wr_sel_q = 0; with ZERO_REG=0 the same sequence returns 32'h12345678 and wr_sel_q = 16'h0001.
- Walk writes of value i+1 to regs 1..15, then read pairs (A=i, B=15-i) -> i+1 and 16-i. Reg 0 reads 0 on either port; with ZERO_REG=1, reg 0 reads 0 whenever addressed.
- Same-cycle write 32'hA5A5A5A5 to reg 3 with A=3, B=3 (reg 3 previously 32'h1):
  - without REGFILE_BYPASS_EN -> both read 32'h1;
  - with it -> both read 32'hA5A5A5A5;
  - next cycle both read 32'hA5A5A5A5.
- rst=1 and ld=1 to reg 7 in the same cycle (reg 7 previously 32'h77) -> reg 7 reads 0 afterward and wr_sel_q = 0.
